multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have the following ports.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode field from the instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  1 = write-back from MDR.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = shifted imm.
- alu_op  out  2  to ALU control decoder: 00 add, 01 sub, 10 funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding.
- illegal_op  out  1  unsupported opcode seen in DECODE.
- instr_count  out  16  retired-instruction counter.

Function
REQ-002 The block SHALL be a registered-state FSM with these encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-003 All outputs SHALL be decoded from the state register (plus mem_ready where stated); unlisted outputs SHALL be 0 in each state.
REQ-004 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready and pc_write=mem_ready; it SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 and branch on op: 100011/101011 -> MEM_ADR, 000000 -> EXEC_R, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> EXEC_I, any other -> FETCH with illegal_op=1 in that DECODE cycle only.
REQ-006 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for op 100011 and MEM_WR for op 101011.
REQ-007 MEM_RD SHALL drive mem_read=1, i_or_d=1, hold while mem_ready=0, and go to MEM_WB on mem_ready=1.
REQ-008 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-009 MEM_WR SHALL drive mem_write=1, i_or_d=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-010 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB; R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-011 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, then go to FETCH.
REQ-012 JUMP SHALL drive pc_source=10 and pc_write=1, then go to FETCH.
REQ-013 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to I_WB; I_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-014 instr_count SHALL increment by 1 on each edge where the state leaves MEM_WB, MEM_WR (with mem_ready=1), R_WB, BRANCH, JUMP or I_WB for FETCH.
REQ-015 instr_count SHALL NOT increment on the illegal-opcode return or on invalid-state recovery, and SHALL wrap from 0xFFFF to 0x0000.
REQ-016 Instruction cycle counts with mem_ready tied to 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-017 When rst=1 at a rising edge, state SHALL become FETCH and instr_count SHALL become 0, regardless of current state or mem_ready.
REQ-018 Reset SHALL take priority over every transition, including mid-wait in MEM_RD/MEM_WR; the first cycle after reset SHALL show FETCH outputs with illegal_op=0.

Verification
REQ-019 Reset then R-type (op=000000), mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_write=1, reg_dst=1 in state 7; instr_count=1.
REQ-020 lw (op=100011) with mem_ready low for 3 cycles in MEM_RD -> state 3 held 4 cycles with mem_read=1, i_or_d=1; then state 4 with mem_to_reg=1; instr_count increments once.
REQ-021 beq (op=000100) -> states 0,1,8,0; pc_write_cond=1, alu_op=01, pc_source=01 in state 8; j (op=000010) -> pc_write=1, pc_source=10 in state 9.
REQ-022 op=111111 in DECODE -> illegal_op=1 for exactly one cycle, next state 0, instr_count unchanged.
REQ-023 Assert rst during MEM_WR with mem_ready=0 -> next cycle state=0, mem_write=0, instr_count=0.
REQ-024 Preload 0xFFFF retirements (or force count), retire one more instruction -> instr_count=0x0000.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-style control FSM with a retired-instruction counter.
// Outputs decode from the state register, plus mem_ready and op where noted.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
        EXEC_R, R_WB, BRANCH, JUMP, EXEC_I, I_WB
    } state_t;

    state_t st, nxt;
    logic [15:0] cnt;
    logic retire, is_lw, is_sw, is_r, is_beq, is_j, is_addi;

    assign is_lw   = op == 6'b100011;
    assign is_sw   = op == 6'b101011;
    assign is_r    = op == 6'b000000;
    assign is_beq  = op == 6'b000100;
    assign is_j    = op == 6'b000010;
    assign is_addi = op == 6'b001000;
    assign state       = st;
    assign instr_count = cnt;

    always_comb begin
        nxt    = FETCH;
        retire = 1'b0;
        case (st)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE:  nxt = (is_lw || is_sw) ? MEM_ADR : is_r ? EXEC_R : is_beq ? BRANCH :
                           is_j ? JUMP : is_addi ? EXEC_I : FETCH;
            MEM_ADR: nxt = is_sw ? MEM_WR : MEM_RD;
            MEM_RD:  nxt = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR: begin
                nxt    = mem_ready ? FETCH : MEM_WR;
                retire = mem_ready;
            end
            EXEC_R:  nxt = R_WB;
            EXEC_I:  nxt = I_WB;
            MEM_WB, R_WB, BRANCH, JUMP, I_WB: retire = 1'b1;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (st)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !(is_lw || is_sw || is_r || is_beq || is_j || is_addi);
            end
            MEM_ADR, EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            I_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= cnt + 16'(retire);
        end
    end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed checks for the named scenarios, then random instruction streams,
// all compared every cycle against an instruction-level model (per-op state path + retire count).
module tb_multi_cycle_ctrl;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
    logic [5:0] op = '0;
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [15:0] instr_count;
    logic [16:0] dut_ctl;

    int n_cmp = 0, n_bad = 0;
    int mq[$];
    logic [15:0] mcnt = '0;
    logic [5:0] cur_op = '0, ro;
    bit chk_en = 1'b0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    assign dut_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                      reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

    always #5 clk = ~clk;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(logic [5:0] o);
        return o inside {LW, SW, RT, BEQ, JMP, ADDI};
    endfunction

    // Control word each state must present, straight from the per-state output rules.
    function automatic logic [16:0] exp_ctl(int s, bit mr, bit ill);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, il;
        logic [1:0] asb, aop, ps;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, il} = '0;
        asb = 2'b00;
        aop = 2'b00;
        ps  = 2'b00;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pwc = 1; end
            9:  begin ps = 2'b10; pw = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, ps, il};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("state", 32'(state), 32'(mq[0]));
            cmp("ctl", 32'(dut_ctl), 32'(exp_ctl(mq[0], mem_ready, mq[0] == 1 && !legal(op))));
            cmp("count", 32'(instr_count), 32'(mcnt));
        end
    end

    // Drive one cycle; the model walks the remaining state path of the current instruction.
    task automatic step(logic [5:0] o, bit mr, bit r);
        op = o;
        mem_ready = mr;
        rst = r;
        @(posedge clk);
        if (r) begin
            mq = {0};
            mcnt = '0;
        end else if (mr || !(mq[0] inside {0, 3, 5})) begin
            if (mq[0] == 0) begin
                cur_op = o;
                case (o)
                    LW:      mq = {1, 2, 3, 4};
                    SW:      mq = {1, 2, 5};
                    RT:      mq = {1, 6, 7};
                    BEQ:     mq = {1, 8};
                    JMP:     mq = {1, 9};
                    ADDI:    mq = {1, 10, 11};
                    default: mq = {1};
                endcase
            end else begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    mq.push_back(0);
                    if (legal(cur_op)) mcnt++;
                end
            end
        end
        #1;
    endtask

    initial begin
        step(RT, 1, 1);
        chk_en = 1'b1;
        cmp("rst_state", 32'(state), 0);
        cmp("rst_count", 32'(instr_count), 0);
        cmp("rst_illegal", 32'(illegal_op), 0);
        cmp("rst_mem_read", 32'(mem_read), 1);
        // R-type
        step(RT, 1, 0); cmp("r_decode", 32'(state), 1);
        step(RT, 1, 0); cmp("r_exec", 32'(state), 6); cmp("r_alu_op", 32'(alu_op), 2);
        step(RT, 1, 0); cmp("r_wb", 32'(state), 7); cmp("r_wb_ctl", 32'({reg_write, reg_dst}), 3);
        step(RT, 1, 0); cmp("r_done", 32'(state), 0); cmp("r_count", 32'(instr_count), 1);
        // lw with a slow memory read
        step(LW, 1, 0); step(LW, 1, 0); step(LW, 1, 0); cmp("lw_rd", 32'(state), 3);
        for (int i = 0; i < 3; i++) begin
            step(LW, 0, 0);
            cmp("lw_wait", 32'({state, mem_read, i_or_d}), 32'({4'd3, 2'b11}));
        end
        step(LW, 1, 0); cmp("lw_wb", 32'({state, mem_to_reg}), 32'({4'd4, 1'b1}));
        step(LW, 1, 0); cmp("lw_count", 32'(instr_count), 2);
        // beq and j
        step(BEQ, 1, 0); step(BEQ, 1, 0);
        cmp("beq_ctl", 32'({state, pc_write_cond, alu_op, pc_source}), 32'({4'd8, 1'b1, 2'b01, 2'b01}));
        step(BEQ, 1, 0); cmp("beq_done", 32'(state), 0);
        step(JMP, 1, 0); step(JMP, 1, 0);
        cmp("j_ctl", 32'({state, pc_write, pc_source}), 32'({4'd9, 1'b1, 2'b10}));
        step(JMP, 1, 0); cmp("j_count", 32'(instr_count), 4);
        // illegal opcode
        step(6'h3f, 1, 0); cmp("ill_flag", 32'({state, illegal_op}), 32'({4'd1, 1'b1}));
        step(6'h3f, 1, 0); cmp("ill_after", 32'({state, illegal_op}), 0); cmp("ill_count", 32'(instr_count), 4);
        // reset while sw waits on memory
        step(SW, 1, 0); step(SW, 1, 0); step(SW, 1, 0); cmp("sw_wr", 32'(state), 5);
        step(SW, 0, 0); cmp("sw_wait", 32'({state, mem_write}), 32'({4'd5, 1'b1}));
        step(SW, 0, 1);
        cmp("sw_rst", 32'({state, mem_write}), 0); cmp("sw_rst_count", 32'(instr_count), 0);
        // counter wrap
        step(JMP, 1, 0); step(JMP, 1, 0);
        force dut.cnt = 16'hffff;
        mcnt = 16'hffff;
        #1;
        release dut.cnt;
        cmp("wrap_pre", 32'(instr_count), 32'hffff);
        step(JMP, 1, 0); cmp("wrap", 32'(instr_count), 0);
        // random instruction streams
        for (int i = 0; i < 4000; i++) begin
            if (mq[0] == 0) begin
                case ($urandom % 8)
                    0: ro = LW;
                    1: ro = SW;
                    2: ro = RT;
                    3: ro = BEQ;
                    4: ro = JMP;
                    5: ro = ADDI;
                    6: ro = 6'h3f;
                    default: ro = 6'($urandom);
                endcase
            end
            step(ro, ($urandom % 4) != 0, ($urandom % 60) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
